// File: rtl/pulse_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_seq_ctrl
//
// Sequencer for the 32-bit command FIFO that feeds pulse_gen. A host fills a
// small table of (coarse, fine) pulse entries. A start request then emits:
//   set_period  {8'd2, period}
//   reset_clock {8'd0, 24'd0}
//   send_pulse  {8'd1, coarse[15:0], fine[7:0]}  for every table entry
// The table pass is repeated cfg_repeat times. A value of 0 repeats until abort.
// When cfg_resync is set, a reset_clock word goes in front of every pass.
//
// FIFO handshake (write side, one rule only):
//   fifo_wr is combinational: it is high in PERIOD/RST/PULSE when fifo_full
//   is low and abort is low. fifo_wdata is valid whenever fifo_wr is high.
//   A word counts as written exactly in a cycle with fifo_wr=1, and the FSM
//   advances only on such a cycle. A full FIFO stalls the FSM on the same
//   word for as long as needed, so no word is ever lost or duplicated.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active low
//   cfg_we      table write strobe (ignored with err while busy or fine > 15)
//   cfg_addr    table write address
//   cfg_data    table entry: [23:8] coarse delay, [7:0] fine delay
//   cfg_len     entries per pass, 1..DEPTH, sampled at start
//   cfg_period  clock period word, sampled at start
//   cfg_repeat  number of passes, 0 = infinite, sampled at start
//   cfg_resync  1: emit reset_clock before every pass, sampled at start
//   start       level, sampled only in IDLE
//   abort       returns the sequencer to IDLE and suppresses the current write
//   fifo_full   FIFO full flag
//   fifo_wr     FIFO write strobe
//   fifo_wdata  FIFO write data {cmd[7:0], payload[23:0]}
//   busy        high in any state other than IDLE
//   done        one-cycle pulse after the last word of the last pass
//   err         one-cycle pulse after a rejected start or table write
//   cur_rep     number of passes completed in the current run
//   state_dbg   current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module pulse_seq_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [23:0]       cfg_data,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [23:0]       cfg_period,
    input  logic [15:0]       cfg_repeat,
    input  logic              cfg_resync,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [31:0]       fifo_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       cur_rep,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PERIOD = 3'd1,
        S_RST    = 3'd2,
        S_PULSE  = 3'd3,
        S_PASS   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0]        CMD_RST    = 8'd0;
    localparam logic [7:0]        CMD_PULSE  = 8'd1;
    localparam logic [7:0]        CMD_PERIOD = 8'd2;
    localparam logic [ADDR_W:0]   LEN_MAX    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);

    state_t state_q, state_d;

    // Run parameters captured at start so the host may reprogram them mid-run.
    logic [ADDR_W:0]   len_q;
    logic [23:0]       period_q;
    logic [15:0]       repeat_q;
    logic              resync_q;

    logic [ADDR_W-1:0] idx_q;
    logic [15:0]       cur_rep_q;
    logic              err_q;

    // Pulse table. Contents are not reset; the host must program it.
    logic [23:0]       table_mem [DEPTH];

    logic len_ok;
    logic start_go;
    logic start_bad;
    logic wr_ok;
    logic last_entry;
    logic rep_hit;
    logic fine_ok;
    logic tbl_we;
    logic tbl_rej;
    logic pulse_wr;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    // abort has priority over start while idle.
    assign start_go  = (state_q == S_IDLE) && start && !abort && len_ok;
    assign start_bad = (state_q == S_IDLE) && start && !abort && !len_ok;

    assign wr_ok      = !fifo_full && !abort;
    assign last_entry = ({1'b0, idx_q} == (len_q - LEN_ONE));
    // Only a finite repeat count can terminate; 0 runs until abort.
    assign rep_hit    = (repeat_q != 16'd0) && (cur_rep_q == repeat_q);

    assign fine_ok = (cfg_data[7:0] <= 8'd15);
    assign tbl_we  = cfg_we && !busy && fine_ok;
    assign tbl_rej = cfg_we && (busy || !fine_ok);

    assign pulse_wr = (state_q == S_PULSE) && fifo_wr;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fifo_wr    = 1'b0;
        fifo_wdata = 32'd0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d = S_PERIOD;
                end
            end

            S_PERIOD: begin
                fifo_wdata = {CMD_PERIOD, period_q};
                fifo_wr    = wr_ok;
                if (wr_ok) begin
                    state_d = S_RST;
                end
            end

            S_RST: begin
                fifo_wdata = {CMD_RST, 24'd0};
                fifo_wr    = wr_ok;
                if (wr_ok) begin
                    state_d = S_PULSE;
                end
            end

            S_PULSE: begin
                fifo_wdata = {CMD_PULSE, table_mem[idx_q]};
                fifo_wr    = wr_ok;
                if (wr_ok && last_entry) begin
                    state_d = S_PASS;
                end
            end

            // One idle cycle between passes; cur_rep already counts the
            // pass that just finished, so the end test can use it directly.
            S_PASS: begin
                if (rep_hit) begin
                    state_d = S_DONE;
                end else if (resync_q) begin
                    state_d = S_RST;
                end else begin
                    state_d = S_PULSE;
                end
            end

            S_DONE: begin
                done    = !abort;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // Run datapath: latched config, table index, pass counter, err pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            period_q  <= 24'd0;
            repeat_q  <= 16'd0;
            resync_q  <= 1'b0;
            idx_q     <= '0;
            cur_rep_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= start_bad || tbl_rej;

            if (start_go) begin
                len_q     <= cfg_len;
                period_q  <= cfg_period;
                repeat_q  <= cfg_repeat;
                resync_q  <= cfg_resync;
                idx_q     <= '0;
                cur_rep_q <= 16'd0;
            end else if (pulse_wr) begin
                if (last_entry) begin
                    idx_q     <= '0;
                    // Wraps naturally at 16'hFFFF in infinite mode.
                    cur_rep_q <= cur_rep_q + 16'd1;
                end else begin
                    idx_q <= idx_q + IDX_ONE;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Table write port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign cur_rep   = cur_rep_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
module tb_pulse_seq_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [23:0]       cfg_data;
    logic [ADDR_W:0]   cfg_len;
    logic [23:0]       cfg_period;
    logic [15:0]       cfg_repeat;
    logic              cfg_resync;
    logic              start;
    logic              abort;
    logic              fifo_full;
    logic              fifo_wr;
    logic [31:0]       fifo_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       cur_rep;
    logic [2:0]        state_dbg;

    always #5 clk = ~clk;

    pulse_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len    (cfg_len),
        .cfg_period (cfg_period),
        .cfg_repeat (cfg_repeat),
        .cfg_resync (cfg_resync),
        .start      (start),
        .abort      (abort),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_rep    (cur_rep),
        .state_dbg  (state_dbg)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_cnt     = 0;

    logic [31:0] got_q[$];
    int          cyc_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Monitor: records every written FIFO word and done pulse, away from the edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (fifo_wr === 1'b1) begin
                got_q.push_back(fifo_wdata);
                cyc_q.push_back(cyc);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic set_cfg(input logic [ADDR_W:0] len, input logic [23:0] per,
                           input logic [15:0] rep, input logic rs);
        cfg_len    = len;
        cfg_period = per;
        cfg_repeat = rep;
        cfg_resync = rs;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        cyc_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic load_t1_table();
        write_entry(4'd0, 24'h000305);
        write_entry(4'd1, 24'h000000);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        set_cfg(5'd0, 24'd0, 16'd0, 1'b0);
        start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
        repeat (3) tick();
        tests_run++; if (fifo_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_wr: got %b want 0", fifo_wr); end
        tests_run++; if (fifo_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", fifo_wdata); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
        tests_run++; if (cur_rep !== 16'd0) begin tests_failed++; $display("FAIL reset_cur_rep: got %0d want 0", cur_rep); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        bit ok;
        int start_cyc;
        logic [31:0] g;
        load_t1_table();
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd1, 1'b0);
        pulse_start();
        start_cyc = cyc;
        wait_idle(50, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL t1_timeout: busy %b want 0", busy); end
        exp_q = '{32'h0200000A, 32'h00000000, 32'h01000305, 32'h01000000};
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL t1_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL t1_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        tests_run++; if (cyc_q.size() < 1 || cyc_q[0] != start_cyc) begin tests_failed++; $display("FAIL t1_latency: first write cycle wrong, start cycle %0d", start_cyc); end
        tests_run++; if (cyc_q.size() != 4 || cyc_q[3] - cyc_q[0] != 3) begin tests_failed++; $display("FAIL t1_consecutive: %0d words not on 4 consecutive cycles", cyc_q.size()); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL t1_done: got %0d pulses want 1", done_cnt); end
        tests_run++; if (cur_rep !== 16'd1) begin tests_failed++; $display("FAIL t1_cur_rep: got %0d want 1", cur_rep); end
    endtask

    task automatic test_resync_repeat();
        bit ok;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd3, 1'b1);
        pulse_start();
        wait_idle(80, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL t2_timeout: busy %b want 0", busy); end
        exp_q = '{32'h0200000A,
                  32'h00000000, 32'h01000305, 32'h01000000,
                  32'h00000000, 32'h01000305, 32'h01000000,
                  32'h00000000, 32'h01000305, 32'h01000000};
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL t2_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL t2_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL t2_done: got %0d pulses want 1", done_cnt); end
        tests_run++; if (cur_rep !== 16'd3) begin tests_failed++; $display("FAIL t2_cur_rep: got %0d want 3", cur_rep); end
    endtask

    task automatic test_full_stall();
        bit ok;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd1, 1'b0);
        pulse_start();      // PERIOD word written this cycle
        tick();             // RST word written this cycle
        tick();             // now in PULSE, entry 0 pending
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++; if (fifo_wr !== 1'b0) begin tests_failed++; $display("FAIL t3_stall_wr%0d: got %b want 0", i, fifo_wr); end
            tick();
        end
        tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL t3_stall_count: got %0d words want 2", got_q.size()); end
        fifo_full = 1'b0;
        wait_idle(50, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL t3_timeout: busy %b want 0", busy); end
        exp_q = '{32'h0200000A, 32'h00000000, 32'h01000305, 32'h01000000};
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL t3_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL t3_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL t3_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd1, 1'b0);
        start = 1'b1;       // held through the first run: must not restart it
        tick();
        for (int i = 0; i < 50; i++) begin
            if (got_q.size() >= 5) break;
            tick();
        end
        start = 1'b0;
        wait_idle(50, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: busy %b want 0", busy); end
        exp_q = '{32'h0200000A, 32'h00000000, 32'h01000305, 32'h01000000,
                  32'h0200000A, 32'h00000000, 32'h01000305, 32'h01000000};
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        // last pulse, PASS, DONE, IDLE, then the next PERIOD word
        tests_run++; if (cyc_q.size() < 5 || cyc_q[4] - cyc_q[3] != 4) begin tests_failed++; $display("FAIL b2b_gap: %0d words, run gap not 4 cycles", cyc_q.size()); end
        tests_run++; if (done_cnt != 2) begin tests_failed++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); end
    endtask

    task automatic test_reject();
        bit ok;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd0, 24'd10, 16'd1, 1'b0);
        pulse_start();
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL t4_len0_err: got %b want 1", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t4_len0_busy: got %b want 0", busy); end
        tick();
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL t4_err_width: got %b want 0", err); end
        set_cfg(5'd17, 24'd10, 16'd1, 1'b0);
        pulse_start();
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL t4_len17_err: got %b want 1", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t4_len17_busy: got %b want 0", busy); end
        tick();
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL t4_no_write: got %0d words want 0", got_q.size()); end
        write_entry(4'd1, 24'h001210);   // fine = 16, must be rejected
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL t4_fine_err: got %b want 1", err); end
        tick();
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL t4_fine_err_width: got %b want 0", err); end
        set_cfg(5'd2, 24'd10, 16'd1, 1'b0);
        pulse_start();
        wait_idle(50, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL t4_timeout: busy %b want 0", busy); end
        g = (got_q.size() >= 4) ? got_q[3] : 32'hxxxxxxxx;
        tests_run++; if (g !== 32'h01000000) begin tests_failed++; $display("FAIL t4_entry_kept: got %h want 01000000", g); end
    endtask

    task automatic test_abort();
        bit found;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd0, 1'b0);
        pulse_start();
        write_entry(4'd5, 24'h000101);   // while busy: rejected
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL t5_busy_we_err: got %b want 1", err); end
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() == 20 && fifo_wr === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL t5_reach20: got %0d words before bound", got_q.size()); end
        abort = 1'b1;
        #1;
        tests_run++; if (fifo_wr !== 1'b0) begin tests_failed++; $display("FAIL t5_suppress: got %b want 0", fifo_wr); end
        tick();
        abort = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t5_busy: got %b want 0", busy); end
        tests_run++; if (cur_rep !== 16'd9) begin tests_failed++; $display("FAIL t5_cur_rep: got %0d want 9", cur_rep); end
        tick();
        tests_run++; if (got_q.size() != 20) begin tests_failed++; $display("FAIL t5_count: got %0d words want 20", got_q.size()); end
        exp_q.push_back(32'h0200000A);
        exp_q.push_back(32'h00000000);
        for (int p = 0; p < 9; p++) begin
            exp_q.push_back(32'h01000305);
            exp_q.push_back(32'h01000000);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL t5_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL t5_done: got %0d pulses want 0", done_cnt); end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [31:0] g;
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd0, 1'b0);
        pulse_start();
        tick();
        tick();             // in PULSE, writing entry 0
        #2;
        rst = 1'b0;
        #1;
        tests_run++; if (fifo_wr !== 1'b0) begin tests_failed++; $display("FAIL t6_fifo_wr: got %b want 0", fifo_wr); end
        tests_run++; if (fifo_wdata !== 32'd0) begin tests_failed++; $display("FAIL t6_wdata: got %h want 0", fifo_wdata); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t6_busy: got %b want 0", busy); end
        tests_run++; if (cur_rep !== 16'd0) begin tests_failed++; $display("FAIL t6_cur_rep: got %0d want 0", cur_rep); end
        tests_run++; if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL t6_state: got %0d want 0", state_dbg); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        load_t1_table();
        clear_sb();
        set_cfg(5'd2, 24'd10, 16'd1, 1'b0);
        pulse_start();
        wait_idle(50, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL t6_timeout: busy %b want 0", busy); end
        exp_q = '{32'h0200000A, 32'h00000000, 32'h01000305, 32'h01000000};
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL t6_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            tests_run++; if (g !== exp_q[i]) begin tests_failed++; $display("FAIL t6_word%0d: got %h want %h", i, g, exp_q[i]); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL t6_done: got %0d pulses want 1", done_cnt); end
        tests_run++; if (cur_rep !== 16'd1) begin tests_failed++; $display("FAIL t6_cur_rep_run: got %0d want 1", cur_rep); end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_pass();
        test_resync_repeat();
        test_full_stall();
        test_back_to_back();
        test_reject();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
